// File: rtl/voter_pkg.sv
// voter_pkg: session state encoding and one-hot verdict constants shared by the voter_seq slice.
package voter_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, TALLY} state_t;
  localparam logic [2:0] VERDICT_PASS = 3'b001;
  localparam logic [2:0] VERDICT_TIE  = 3'b010;
  localparam logic [2:0] VERDICT_FAIL = 3'b100;
  localparam logic [2:0] VERDICT_NONE = 3'b000;
endpackage

// File: rtl/voter_popcount.sv
// voter_popcount: combinational population count of an N-bit vector into W bits.
module voter_popcount #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] v,
  output logic [W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + W'(v[i]);
  end
endmodule

// File: rtl/voter_seq.sv
// voter_seq: timed N-voter ballot session with a registered one-hot verdict and counts.
// Optional quorum check is enabled by defining VOTER_QUORUM_EN.
module voter_seq
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int TIMEOUT  = 16,
  parameter int QUORUM   = 3,
  parameter int CNT_W    = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic                done,
  output logic [3:1]          Out,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic                no_quorum
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [N_VOTERS-1:0] voted, acc;
  logic [CNT_W-1:0] yes_acc, no_acc, yes_new, no_new, yes_sum, no_sum;
  logic [TW-1:0] timer;
  logic fin;
  logic [2:0] verdict;
  assign acc = (state == COLLECT) ? (vote_valid & ~voted) : '0;
  voter_popcount #(.N(N_VOTERS), .W(CNT_W)) u_yes (.v(acc & vote_yes),  .cnt(yes_new));
  voter_popcount #(.N(N_VOTERS), .W(CNT_W)) u_no  (.v(acc & ~vote_yes), .cnt(no_new));
  assign yes_sum = yes_acc + yes_new;
  assign no_sum  = no_acc + no_new;
  assign fin     = (&(voted | acc)) || (timer == TW'(TIMEOUT - 1));
  assign busy    = state != IDLE;
  always_comb verdict = (yes_sum > no_sum) ? VERDICT_PASS : (yes_sum == no_sum) ? VERDICT_TIE : VERDICT_FAIL;
`ifdef VOTER_QUORUM_EN
  logic below_q;
  assign below_q = (32'(yes_sum) + 32'(no_sum)) < QUORUM;
`else
  assign no_quorum = 1'b0;
`endif
  // Results are registered on the COLLECT exit edge so done/Out are visible during TALLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      Out     <= '0;
      yes_cnt <= '0;
      no_cnt  <= '0;
      voted   <= '0;
      yes_acc <= '0;
      no_acc  <= '0;
      timer   <= '0;
`ifdef VOTER_QUORUM_EN
      no_quorum <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          voted   <= '0;
          yes_acc <= '0;
          no_acc  <= '0;
          timer   <= '0;
          if (start) state <= COLLECT;
        end
        COLLECT: begin
          if (abort) state <= IDLE;
          else begin
            voted   <= voted | acc;
            yes_acc <= yes_sum;
            no_acc  <= no_sum;
            timer   <= timer + 1'b1;
            if (fin) begin
              state   <= TALLY;
              done    <= 1'b1;
              yes_cnt <= yes_sum;
              no_cnt  <= no_sum;
`ifdef VOTER_QUORUM_EN
              Out       <= below_q ? VERDICT_NONE : verdict;
              no_quorum <= below_q;
`else
              Out <= verdict;
`endif
            end
          end
        end
        TALLY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
